apu_aout_sched: RTL and testbench

Stereo audio output scheduler between the APU sample producer and the two per-channel sigma-delta PWM modulators.
- Buffers signed stereo samples in a small FIFO.
- Paces them out at a programmable sample rate, counted in units of 16-clock PWM frames.
- Converts each sample to offset-binary and presents it to the modulators, updating only at a PWM frame boundary.
- Reports FIFO level, a low-water request and sticky underrun.

---
 rtl/apu_aout_sched_if.sv | 12 +
 rtl/apu_aout_sched.sv | 162 ++++++++++++++++
 tb/tb_apu_aout_sched.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apu_aout_sched_if.sv
// Stereo sample stream from the APU producer into the output scheduler.
interface apu_aout_sched_if #(
    parameter int unsigned W_SAMPLE = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [W_SAMPLE-1:0] in_l;
    logic [W_SAMPLE-1:0] in_r;

    modport master (output in_valid, output in_l, output in_r, input in_ready);
    modport slave  (input in_valid, input in_l, input in_r, output in_ready);
endinterface

// File: rtl/apu_aout_sched.sv
// Stereo audio output scheduler: sample FIFO, frame-aligned rate pacing and
// offset-binary conversion feeding two sigma-delta PWM modulators.
module apu_aout_sched #(
    parameter int unsigned W_SAMPLE   = 16,
    parameter int unsigned W_PWM      = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned W_DIV      = 8,
    localparam int unsigned W_PTR     = $clog2(FIFO_DEPTH),
    localparam int unsigned W_LVL     = W_PTR + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_en,
    input  logic [W_DIV-1:0]    cfg_div,
    input  logic [W_LVL-1:0]    cfg_lowwater,
    input  logic                cfg_flush,
    input  logic                underrun_clr,
    apu_aout_sched_if.slave     in_if,
    output logic [W_SAMPLE-1:0] sdm_l,
    output logic [W_SAMPLE-1:0] sdm_r,
    output logic [W_LVL-1:0]    fifo_level,
    output logic                lowwater,
    output logic                underrun
);

    localparam logic [W_SAMPLE-1:0] MIDSCALE = {1'b1, {(W_SAMPLE-1){1'b0}}};
    localparam logic [W_LVL-1:0]    LVL_FULL = W_LVL'(FIFO_DEPTH);

    logic [W_PWM-1:0]    frame_ctr_q;
    logic                frame_end;
    logic [W_DIV-1:0]    rate_ctr_q, rate_ctr_d;
    logic                tick;

    logic [W_SAMPLE-1:0] mem_l [FIFO_DEPTH];
    logic [W_SAMPLE-1:0] mem_r [FIFO_DEPTH];
    logic [W_PTR-1:0]    wr_ptr_q, wr_ptr_d;
    logic [W_PTR-1:0]    rd_ptr_q, rd_ptr_d;
    logic [W_LVL-1:0]    level_q, level_d;
    logic                fifo_empty;
    logic                push, pop, starve;

    logic [W_SAMPLE-1:0] sdm_l_q, sdm_l_d;
    logic [W_SAMPLE-1:0] sdm_r_q, sdm_r_d;
    logic                underrun_q, underrun_d;

    function automatic logic [W_SAMPLE-1:0] to_offset(input logic [W_SAMPLE-1:0] s);
        return {~s[W_SAMPLE-1], s[W_SAMPLE-2:0]};
    endfunction

    // Shares reset with the modulators, so frame_end lines up with their PWM wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_ctr_q <= '0;
        end else begin
            frame_ctr_q <= frame_ctr_q + W_PWM'(1);
        end
    end

    assign frame_end = &frame_ctr_q;

    always_comb begin
        rate_ctr_d = rate_ctr_q;
        tick       = 1'b0;
        if (frame_end) begin
            if (!cfg_en) begin
                rate_ctr_d = '0;
            end else if (rate_ctr_q == '0) begin
                tick       = 1'b1;
                rate_ctr_d = cfg_div;
            end else begin
                rate_ctr_d = rate_ctr_q - W_DIV'(1);
            end
        end
    end

    assign in_if.in_ready = (level_q < LVL_FULL);
    assign fifo_empty     = (level_q == '0);

    // Flush wins over both ports; a tick colliding with it sees an empty FIFO.
    assign push   = in_if.in_valid && in_if.in_ready && !cfg_flush;
    assign pop    = tick && !fifo_empty && !cfg_flush;
    assign starve = tick && (fifo_empty || cfg_flush);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (cfg_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + W_PTR'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + W_PTR'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + W_LVL'(1);
                2'b01:   level_d = level_q - W_LVL'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_l[wr_ptr_q] <= in_if.in_l;
            mem_r[wr_ptr_q] <= in_if.in_r;
        end
    end

    // Outputs only move on frame_end, so each value spans whole PWM frames.
    always_comb begin
        sdm_l_d = sdm_l_q;
        sdm_r_d = sdm_r_q;
        if (pop) begin
            sdm_l_d = to_offset(mem_l[rd_ptr_q]);
            sdm_r_d = to_offset(mem_r[rd_ptr_q]);
        end else if (frame_end && !cfg_en) begin
            sdm_l_d = MIDSCALE;
            sdm_r_d = MIDSCALE;
        end
    end

    always_comb begin
        underrun_d = underrun_q;
        if (starve) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_ctr_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            sdm_l_q    <= MIDSCALE;
            sdm_r_q    <= MIDSCALE;
            underrun_q <= 1'b0;
        end else begin
            rate_ctr_q <= rate_ctr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            sdm_l_q    <= sdm_l_d;
            sdm_r_q    <= sdm_r_d;
            underrun_q <= underrun_d;
        end
    end

    assign sdm_l      = sdm_l_q;
    assign sdm_r      = sdm_r_q;
    assign fifo_level = level_q;
    assign underrun   = underrun_q;
    assign lowwater   = cfg_en && (level_q <= cfg_lowwater);

endmodule

// File: tb/tb_apu_aout_sched.sv
// Directed bench for apu_aout_sched: a vector table for pacing/underrun plus
// hand-written sequences for full-FIFO, flush and disable corner cases.
module tb_apu_aout_sched;

    localparam int unsigned W_SAMPLE   = 16;
    localparam int unsigned W_PWM      = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned W_DIV      = 8;
    localparam int unsigned W_LVL      = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                cfg_en = 1'b0;
    logic [W_DIV-1:0]    cfg_div = '0;
    logic [W_LVL-1:0]    cfg_lowwater = '0;
    logic                cfg_flush = 1'b0;
    logic                underrun_clr = 1'b0;
    logic [W_SAMPLE-1:0] sdm_l, sdm_r;
    logic [W_LVL-1:0]    fifo_level;
    logic                lowwater, underrun;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    apu_aout_sched_if #(.W_SAMPLE(W_SAMPLE)) sif ();

    apu_aout_sched #(
        .W_SAMPLE  (W_SAMPLE),
        .W_PWM     (W_PWM),
        .FIFO_DEPTH(FIFO_DEPTH),
        .W_DIV     (W_DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_en      (cfg_en),
        .cfg_div     (cfg_div),
        .cfg_lowwater(cfg_lowwater),
        .cfg_flush   (cfg_flush),
        .underrun_clr(underrun_clr),
        .in_if       (sif),
        .sdm_l       (sdm_l),
        .sdm_r       (sdm_r),
        .fifo_level  (fifo_level),
        .lowwater    (lowwater),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic        en;
        logic [7:0]  div;
        logic        valid;
        logic [15:0] l;
        logic [15:0] r;
        logic        clr;
        logic [15:0] e_l;
        logic [15:0] e_r;
        logic [2:0]  e_lvl;
        logic        e_rdy;
        logic        e_ur;
        logic        e_lw;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Outputs are sampled and inputs driven on the falling edge.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n        = 1'b0;
        cfg_en       = 1'b0;
        cfg_div      = '0;
        cfg_lowwater = '0;
        cfg_flush    = 1'b0;
        underrun_clr = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_l     = '0;
        sif.in_r     = '0;
        #1;
        chk("rst.sdm_l", 32'(sdm_l), 'h8000);
        chk("rst.sdm_r", 32'(sdm_r), 'h8000);
        chk("rst.level", 32'(fifo_level), 0);
        chk("rst.ready", 32'(sif.in_ready), 1);
        chk("rst.underrun", 32'(underrun), 0);
        chk("rst.lowwater", 32'(lowwater), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    function automatic vec_t mkv(int n, logic en, logic [7:0] div, logic valid,
                                 logic [15:0] l, logic [15:0] r, logic clr,
                                 logic [15:0] e_l, logic [15:0] e_r, logic [2:0] e_lvl,
                                 logic e_rdy, logic e_ur, logic e_lw);
        vec_t v;
        v = '{n, en, div, valid, l, r, clr, e_l, e_r, e_lvl, e_rdy, e_ur, e_lw};
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        // div=3: ticks at cycles 16, 80, 144, 208; div=0 reload at 208 -> ticks 272, 288.
        tbl.push_back(mkv( 1, 1, 3, 1, 16'h0001, 16'hFFFF, 0, 16'h8000, 16'h8000, 1, 1, 0, 0));
        tbl.push_back(mkv( 1, 1, 3, 1, 16'h0002, 16'hFFFE, 0, 16'h8000, 16'h8000, 2, 1, 0, 0));
        tbl.push_back(mkv( 1, 1, 3, 1, 16'h0003, 16'hFFFD, 0, 16'h8000, 16'h8000, 3, 1, 0, 0));
        tbl.push_back(mkv( 1, 1, 3, 1, 16'h0004, 16'hFFFC, 0, 16'h8000, 16'h8000, 4, 0, 0, 0));
        tbl.push_back(mkv(11, 1, 3, 0, 16'h0000, 16'h0000, 0, 16'h8000, 16'h8000, 4, 0, 0, 0));
        tbl.push_back(mkv( 1, 1, 3, 0, 16'h0000, 16'h0000, 0, 16'h8001, 16'h7FFF, 3, 1, 0, 0));
        tbl.push_back(mkv(63, 1, 3, 0, 16'h0000, 16'h0000, 0, 16'h8001, 16'h7FFF, 3, 1, 0, 0));
        tbl.push_back(mkv( 1, 1, 3, 0, 16'h0000, 16'h0000, 0, 16'h8002, 16'h7FFE, 2, 1, 0, 0));
        tbl.push_back(mkv(64, 1, 3, 0, 16'h0000, 16'h0000, 0, 16'h8003, 16'h7FFD, 1, 1, 0, 0));
        tbl.push_back(mkv(64, 1, 3, 0, 16'h0000, 16'h0000, 0, 16'h8004, 16'h7FFC, 0, 1, 0, 1));
        tbl.push_back(mkv(63, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h8004, 16'h7FFC, 0, 1, 0, 1));
        tbl.push_back(mkv( 1, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h8004, 16'h7FFC, 0, 1, 1, 1));
        tbl.push_back(mkv(15, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h8004, 16'h7FFC, 0, 1, 1, 1));
        tbl.push_back(mkv( 1, 1, 0, 0, 16'h0000, 16'h0000, 1, 16'h8004, 16'h7FFC, 0, 1, 1, 1));
        tbl.push_back(mkv( 1, 1, 0, 0, 16'h0000, 16'h0000, 1, 16'h8004, 16'h7FFC, 0, 1, 0, 1));
        tbl.push_back(mkv( 1, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h8004, 16'h7FFC, 0, 1, 0, 1));

        // First push lands exactly at the first frame boundary.
        do_reset();
        cfg_en  = 1'b1;
        cfg_div = 8'd0;
        step();
        sif.in_valid = 1'b1;
        sif.in_l     = 16'h0000;
        sif.in_r     = 16'hFFFF;
        step();
        sif.in_valid = 1'b0;
        chk("a.level", 32'(fifo_level), 1);
        chk("a.lowwater", 32'(lowwater), 0);
        while (cyc < 15) begin
            step();
            chk("a.hold_r", 32'(sdm_r), 'h8000);
        end
        step();
        chk("a.sdm_l", 32'(sdm_l), 'h8000);
        chk("a.sdm_r", 32'(sdm_r), 'h7FFF);
        chk("a.level_pop", 32'(fifo_level), 0);
        chk("a.underrun", 32'(underrun), 0);
        chk("a.lowwater_empty", 32'(lowwater), 1);
        step_to(31);
        chk("a.underrun_31", 32'(underrun), 0);
        step();
        chk("a.underrun_32", 32'(underrun), 1);
        chk("a.hold_after_ur", 32'(sdm_r), 'h7FFF);

        // Pacing, drain and underrun set/clear via the vector table.
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            cfg_en       = tbl[i].en;
            cfg_div      = tbl[i].div;
            sif.in_valid = tbl[i].valid;
            sif.in_l     = tbl[i].l;
            sif.in_r     = tbl[i].r;
            underrun_clr = tbl[i].clr;
            repeat (tbl[i].n) step();
            chk($sformatf("v%0d.sdm_l", i), 32'(sdm_l), 32'(tbl[i].e_l));
            chk($sformatf("v%0d.sdm_r", i), 32'(sdm_r), 32'(tbl[i].e_r));
            chk($sformatf("v%0d.level", i), 32'(fifo_level), 32'(tbl[i].e_lvl));
            chk($sformatf("v%0d.ready", i), 32'(sif.in_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d.underrun", i), 32'(underrun), 32'(tbl[i].e_ur));
            chk($sformatf("v%0d.lowwater", i), 32'(lowwater), 32'(tbl[i].e_lw));
        end

        // Full FIFO with valid held: a pop frees space but no same-cycle push.
        do_reset();
        cfg_en       = 1'b1;
        cfg_div      = 8'd0;
        sif.in_valid = 1'b1;
        while (cyc < 17) begin
            sif.in_l = 16'h0100 + 16'(cyc);
            sif.in_r = sif.in_l;
            step();
            if (cyc == 4) begin
                chk("c.level_full", 32'(fifo_level), 4);
                chk("c.ready_full", 32'(sif.in_ready), 0);
            end
            if (cyc == 16) begin
                chk("c.level_pop", 32'(fifo_level), 3);
                chk("c.sdm_l_pop", 32'(sdm_l), 'h8100);
                chk("c.ready_pop", 32'(sif.in_ready), 1);
            end
            if (cyc == 17) chk("c.level_refill", 32'(fifo_level), 4);
        end
        sif.in_valid = 1'b0;
        step_to(32);
        chk("c.sdm_l_32", 32'(sdm_l), 'h8101);
        step_to(80);
        chk("c.sdm_l_80", 32'(sdm_l), 'h8110);
        chk("c.sdm_r_80", 32'(sdm_r), 'h8110);
        chk("c.level_80", 32'(fifo_level), 0);

        // Pre-fill while disabled, then flush with a competing push.
        do_reset();
        sif.in_valid = 1'b1;
        sif.in_l     = 16'h0AAA;
        sif.in_r     = 16'h0AAA;
        step();
        step();
        chk("d.level_prefill", 32'(fifo_level), 2);
        chk("d.lowwater_dis", 32'(lowwater), 0);
        sif.in_l  = 16'h1234;
        sif.in_r  = 16'h1234;
        cfg_flush = 1'b1;
        step();
        cfg_flush    = 1'b0;
        sif.in_valid = 1'b0;
        chk("d.level_flush", 32'(fifo_level), 0);
        chk("d.ready_flush", 32'(sif.in_ready), 1);
        cfg_en = 1'b1;
        step_to(13);
        sif.in_valid = 1'b1;
        step();
        sif.in_valid = 1'b0;
        chk("d.level_one", 32'(fifo_level), 1);
        step();
        cfg_flush = 1'b1;
        step();
        cfg_flush = 1'b0;
        chk("d.level_tickflush", 32'(fifo_level), 0);
        chk("d.underrun_tickflush", 32'(underrun), 1);
        chk("d.sdm_l", 32'(sdm_l), 'h8000);
        chk("d.sdm_r", 32'(sdm_r), 'h8000);

        // Disable mid-frame returns to midscale on the next frame boundary.
        do_reset();
        cfg_en       = 1'b1;
        cfg_div      = 8'd0;
        sif.in_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            sif.in_l = 16'(k * 'h100);
            sif.in_r = sif.in_l;
            step();
        end
        sif.in_valid = 1'b0;
        step_to(32);
        chk("e.sdm_l_32", 32'(sdm_l), 'h8200);
        chk("e.level_32", 32'(fifo_level), 1);
        step_to(40);
        cfg_en = 1'b0;
        step_to(47);
        chk("e.sdm_l_47", 32'(sdm_l), 'h8200);
        step();
        chk("e.sdm_l_48", 32'(sdm_l), 'h8000);
        chk("e.sdm_r_48", 32'(sdm_r), 'h8000);
        chk("e.lowwater_48", 32'(lowwater), 0);
        chk("e.level_48", 32'(fifo_level), 1);
        step_to(50);
        cfg_en       = 1'b1;
        cfg_lowwater = 3'd1;
        step();
        chk("e.lowwater_en", 32'(lowwater), 1);
        step_to(64);
        chk("e.sdm_l_64", 32'(sdm_l), 'h8300);
        chk("e.level_64", 32'(fifo_level), 0);
        chk("e.underrun_64", 32'(underrun), 0);

        // Asynchronous reset with non-midscale outputs.
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
